// File: rtl/gate_unit_scheduler.sv
// Round-robin scheduler sharing one AND/OR/NOT/BUF unit among NUM_REQ requesters.
// Optional per-requester grant counters when GATE_SCHED_STATS_EN is defined.
module gate_unit_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [2*NUM_REQ-1:0]       op,
   input  logic [WIDTH*NUM_REQ-1:0]   a,
   input  logic [WIDTH*NUM_REQ-1:0]   b,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       res_valid,
   output logic [WIDTH-1:0]           res_data,
   output logic [$clog2(NUM_REQ)-1:0] res_id
`ifdef GATE_SCHED_STATS_EN
   ,
   output logic [8*NUM_REQ-1:0]       grant_cnt
`endif
);

   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state, state_d;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     pick;
   logic [IDW-1:0]     sidx;
   logic               hit;
   logic [1:0]         cop;
   logic [WIDTH-1:0]   ca, cb, fres;
   logic [NUM_REQ-1:0] gnt_d;
   logic               rv_d;
   logic [WIDTH-1:0]   data_d;
   logic [IDW-1:0]     id_d;
   logic               take;

   // First requester after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      hit  = 1'b0;
      pick = '0;
      sidx = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sidx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
         if (!hit && req[sidx]) begin
            hit  = 1'b1;
            pick = sidx;
         end
      end
   end

   assign take = (state == IDLE) && hit;

   always_comb begin
      unique case (cop)
         2'b00:   fres = ca & cb;
         2'b01:   fres = ca | cb;
         2'b10:   fres = ~ca;
         default: fres = ca;
      endcase
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (hit) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d  = '0;
      rv_d   = 1'b0;
      data_d = res_data;
      id_d   = res_id;
      if (take)
         gnt_d[pick] = 1'b1;
      if (state == EXEC) begin
         rv_d   = 1'b1;
         data_d = fres;
         id_d   = rr_ptr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= IDW'(NUM_REQ - 1);
         gnt       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= '0;
         cop       <= '0;
         ca        <= '0;
         cb        <= '0;
      end else begin
         state     <= state_d;
         gnt       <= gnt_d;
         res_valid <= rv_d;
         res_data  <= data_d;
         res_id    <= id_d;
         // rr_ptr doubles as the owner id of the in-flight op
         if (take) begin
            rr_ptr <= pick;
            cop    <= op[2*pick +: 2];
            ca     <= a[WIDTH*pick +: WIDTH];
            cb     <= b[WIDTH*pick +: WIDTH];
         end
      end
   end

`ifdef GATE_SCHED_STATS_EN
   logic [7:0] cnt [NUM_REQ];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= '0;
      end else if (take && cnt[pick] != 8'hFF) begin
         cnt[pick] <= cnt[pick] + 8'd1;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      assign grant_cnt[8*g +: 8] = cnt[g];
   end
`endif

endmodule
